// File: rtl/sensor_conditioner.sv
// ---------------------------------------------------------------------------
// sensor_conditioner
//
// Conditions the raw secondary-road vehicle sensor for the traffic light
// controller. The raw input is synchronized, debounced by a four-state FSM
// with a stability counter, and turned into a latched "vehicle waiting"
// request plus a saturating count of arrivals since the last service.
//
// Optional feature (macro SENSOR_STUCK_DETECT_EN):
//   When defined, a 24-bit counter measures how long the debounced level has
//   been high. Reaching STUCK_COUNT sets a sticky fault flag, and the fault
//   forces vehicleWaiting high so the secondary road keeps being served.
//   When undefined, no stuck counter exists and sensorStuckFault is tied low.
//
// Parameters:
//   DEBOUNCE_COUNT  cycles a synchronized level must hold to be accepted
//                   (2..255)
//   STUCK_COUNT     cycles of accepted-high level that flag a stuck sensor
//                   (2..2^24-1)
//
// Ports:
//   clk               in   system clock, all logic on the rising edge
//   reset             in   synchronous, active-high reset
//   sensorRaw         in   raw vehicle sensor, asynchronous to clk
//   serviceAck        in   one-cycle pulse: secondary road green started
//   vehicleWaiting    out  registered request to the light controller
//   vehicleCount[3:0] out  registered arrivals since last serviceAck (sat. 15)
//   sensorStuckFault  out  registered sticky stuck-sensor flag
// ---------------------------------------------------------------------------
module sensor_conditioner #(
    parameter int unsigned DEBOUNCE_COUNT = 16,
    parameter int unsigned STUCK_COUNT    = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensorRaw,
    input  logic       serviceAck,
    output logic       vehicleWaiting,
    output logic [3:0] vehicleCount,
    output logic       sensorStuckFault
);

    localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE_COUNT);
    localparam logic [3:0] COUNT_MAX = 4'd15;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        QUAL_HIGH = 2'd1,
        HIGH      = 2'd2,
        QUAL_LOW  = 2'd3
    } deb_state_e;

    // -----------------------------------------------------------------------
    // Two-flop synchronizer. Nothing downstream looks at sensorRaw directly.
    // -----------------------------------------------------------------------
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic synced;

    always_comb begin
        sync1_d = sensorRaw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign synced = sync2_q;

    // -----------------------------------------------------------------------
    // Debounce FSM. A qualifying state is entered on the first sample of the
    // new level with the counter at 1; the level is accepted once the counter
    // has reached DEBOUNCE_COUNT and the sample still agrees. Any disagreeing
    // sample during qualification returns to the previous stable state.
    // The arrival event is registered so that it is a clean one-cycle pulse
    // coinciding with the first cycle in HIGH.
    // -----------------------------------------------------------------------
    deb_state_e state_q, state_d;
    logic [7:0] stab_cnt_q, stab_cnt_d;
    logic       arrival_q, arrival_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOW;
            stab_cnt_q <= 8'd0;
            arrival_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            arrival_q  <= arrival_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        arrival_d  = 1'b0;
        case (state_q)
            LOW: begin
                if (synced) begin
                    state_d    = QUAL_HIGH;
                    stab_cnt_d = 8'd1;
                end
            end
            QUAL_HIGH: begin
                if (!synced) begin
                    state_d    = LOW;
                    stab_cnt_d = 8'd0;
                end else if (stab_cnt_q == DEB_LIMIT) begin
                    state_d    = HIGH;
                    stab_cnt_d = 8'd0;
                    arrival_d  = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + 8'd1;
                end
            end
            HIGH: begin
                if (!synced) begin
                    state_d    = QUAL_LOW;
                    stab_cnt_d = 8'd1;
                end
            end
            QUAL_LOW: begin
                if (synced) begin
                    state_d    = HIGH;
                    stab_cnt_d = 8'd0;
                end else if (stab_cnt_q == DEB_LIMIT) begin
                    state_d    = LOW;
                    stab_cnt_d = 8'd0;
                end else begin
                    stab_cnt_d = stab_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = LOW;
                stab_cnt_d = 8'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Stuck-sensor detection. The debounced level counts as high in both
    // HIGH and QUAL_LOW, so a sensor chattering briefly low does not restart
    // the measurement. The counter saturates rather than wrapping so a very
    // long stuck period cannot alias back below the threshold.
    // -----------------------------------------------------------------------
    logic fault_active;

`ifdef SENSOR_STUCK_DETECT_EN
    localparam logic [23:0] STUCK_LIMIT = 24'(STUCK_COUNT);

    logic [23:0] stuck_cnt_q, stuck_cnt_d;
    logic        stuck_fault_q, stuck_fault_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            stuck_cnt_q   <= 24'd0;
            stuck_fault_q <= 1'b0;
        end else begin
            stuck_cnt_q   <= stuck_cnt_d;
            stuck_fault_q <= stuck_fault_d;
        end
    end

    always_comb begin
        stuck_cnt_d   = 24'd0;
        stuck_fault_d = stuck_fault_q | (stuck_cnt_q == STUCK_LIMIT);
        if ((state_q == HIGH) || (state_q == QUAL_LOW)) begin
            if (stuck_cnt_q != 24'hFF_FFFF) begin
                stuck_cnt_d = stuck_cnt_q + 24'd1;
            end else begin
                stuck_cnt_d = stuck_cnt_q;
            end
        end
    end

    assign fault_active     = stuck_fault_q;
    assign sensorStuckFault = stuck_fault_q;
`else
    assign fault_active     = 1'b0;
    assign sensorStuckFault = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Request latch and arrival counter. An arrival wins over a coincident
    // serviceAck: the ack clears the old backlog and the new arrival becomes
    // the first of the next one. Releasing the sensor never clears the
    // request. A stuck fault holds the request high regardless of acks.
    // -----------------------------------------------------------------------
    logic       waiting_q, waiting_d;
    logic [3:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            waiting_q <= 1'b0;
            count_q   <= 4'd0;
        end else begin
            waiting_q <= waiting_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        waiting_d = waiting_q;
        count_d   = count_q;
        if (arrival_q) begin
            waiting_d = 1'b1;
            if (serviceAck) begin
                count_d = 4'd1;
            end else if (count_q != COUNT_MAX) begin
                count_d = count_q + 4'd1;
            end
        end else if (serviceAck) begin
            waiting_d = 1'b0;
            count_d   = 4'd0;
        end
        if (fault_active) begin
            waiting_d = 1'b1;
        end
    end

    assign vehicleWaiting = waiting_q;
    assign vehicleCount   = count_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// tb_sensor_conditioner
//
// Bench for sensor_conditioner with DEBOUNCE_COUNT=4, STUCK_COUNT=50.
// A reference model, written as a run-length acceptance rule rather than a
// state machine, predicts the outputs for every cycle; predictions are
// queued when the inputs are driven and compared after the clock edge.
// A segment table and a few hand-written sequences add fixed expectations
// at the interesting points.
// ---------------------------------------------------------------------------
module tb_sensor_conditioner;

    localparam int DEB   = 4;
    localparam int STUCK = 50;

`ifdef SENSOR_STUCK_DETECT_EN
    localparam logic STUCK_EN = 1'b1;
`else
    localparam logic STUCK_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       sensorRaw;
    logic       serviceAck;
    logic       vehicleWaiting;
    logic [3:0] vehicleCount;
    logic       sensorStuckFault;

    int checks = 0;
    int errors = 0;

    sensor_conditioner #(
        .DEBOUNCE_COUNT(DEB),
        .STUCK_COUNT   (STUCK)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sensorRaw       (sensorRaw),
        .serviceAck      (serviceAck),
        .vehicleWaiting  (vehicleWaiting),
        .vehicleCount    (vehicleCount),
        .sensorStuckFault(sensorStuckFault)
    );

    // 10 MHz clock
    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Hard time limit so the run always ends on its own
    initial begin
        #20ms;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic       wait_exp;
        logic [3:0] count_exp;
        logic       fault_exp;
    } exp_t;

    exp_t scoreboard[$];

    typedef struct {
        logic       rst;
        logic       raw;
        logic       ack;
        int         len;
        logic       wait_exp;
        logic [3:0] count_exp;
    } seg_t;

    seg_t segs[$];

    // Reference model state
    logic       m_s1, m_s2, m_prev, m_acc, m_arr, m_wait, m_fault;
    logic [3:0] m_cnt;
    int         m_run, m_stuck;

    // The model accepts a new level once DEB+1 consecutive synchronized
    // samples agree on it; the arrival pulse follows acceptance by one cycle
    // and the outputs follow the pulse by one more.
    task automatic modelStep(input logic rst, input logic raw, input logic ack);
        logic       synced, acc_n, arr_n, wait_n, fault_n;
        logic [3:0] cnt_n;
        int         run_n, stuck_n;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_prev = 0; m_acc = 0; m_arr = 0;
            m_wait = 0; m_fault = 0; m_cnt = 0; m_run = 0; m_stuck = 0;
            return;
        end
        synced = m_s2;
        run_n  = (synced == m_prev) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
        acc_n  = m_acc;
        if ((synced != m_acc) && (run_n >= DEB + 1)) acc_n = synced;
        arr_n  = !m_acc && acc_n;
        wait_n = m_wait;
        cnt_n  = m_cnt;
        if (m_arr) begin
            wait_n = 1'b1;
            cnt_n  = ack ? 4'd1 : ((m_cnt == 4'd15) ? 4'd15 : m_cnt + 4'd1);
        end else if (ack) begin
            wait_n = 1'b0;
            cnt_n  = 4'd0;
        end
        if (STUCK_EN) begin
            if (m_fault) wait_n = 1'b1;
            stuck_n = m_acc ? m_stuck + 1 : 0;
            fault_n = m_fault || (m_stuck == STUCK);
        end else begin
            stuck_n = 0;
            fault_n = 1'b0;
        end
        m_run = run_n; m_prev = synced; m_acc = acc_n; m_arr = arr_n;
        m_wait = wait_n; m_cnt = cnt_n; m_stuck = stuck_n; m_fault = fault_n;
        m_s2 = m_s1; m_s1 = raw;
    endtask

    task automatic checkValue(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        e = scoreboard.pop_front();
        checkValue("sb_wait",  {3'b0, vehicleWaiting},   {3'b0, e.wait_exp});
        checkValue("sb_count", vehicleCount,             e.count_exp);
        checkValue("sb_fault", {3'b0, sensorStuckFault}, {3'b0, e.fault_exp});
    endtask

    // One clock cycle: drive inputs, queue prediction, compare after the edge
    task automatic applyStimulus(input logic rst, input logic raw, input logic ack);
        exp_t e;
        @(negedge clk);
        reset      = rst;
        sensorRaw  = raw;
        serviceAck = ack;
        modelStep(rst, raw, ack);
        e.wait_exp  = m_wait;
        e.count_exp = m_cnt;
        e.fault_exp = m_fault;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    function automatic seg_t mkSeg(logic rst, logic raw, logic ack, int len,
                                   logic w, logic [3:0] c);
        seg_t s;
        s.rst = rst; s.raw = raw; s.ack = ack; s.len = len;
        s.wait_exp = w; s.count_exp = c;
        return s;
    endfunction

    task automatic highLowPair();
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        sensorRaw  = 1'b0;
        serviceAck = 1'b0;

        // Segment table: reset, short glitches, 17 arrivals, acks
        segs.push_back(mkSeg(1, 0, 0, 2, 0, 0));
        for (int i = 0; i < 5; i++) begin
            segs.push_back(mkSeg(0, 1, 0, 3, 0, 0));
            segs.push_back(mkSeg(0, 0, 0, 10, 0, 0));
        end
        for (int i = 0; i < 17; i++) begin
            segs.push_back(mkSeg(0, 1, 0, 6, (i > 0), 4'((i > 15) ? 15 : i)));
            segs.push_back(mkSeg(0, 0, 0, 6, 1, 4'((i + 1 > 15) ? 15 : i + 1)));
        end
        segs.push_back(mkSeg(0, 0, 1, 1, 0, 0));
        segs.push_back(mkSeg(0, 0, 1, 1, 0, 0));
        segs.push_back(mkSeg(0, 0, 0, 3, 0, 0));

        $display("[TB] segment table: %0d segments", segs.size());
        for (int s = 0; s < segs.size(); s++) begin
            for (int k = 0; k < segs[s].len; k++)
                applyStimulus(segs[s].rst, segs[s].raw, segs[s].ack);
            checkValue($sformatf("seg%0d_wait", s), {3'b0, vehicleWaiting}, {3'b0, segs[s].wait_exp});
            checkValue($sformatf("seg%0d_count", s), vehicleCount, segs[s].count_exp);
        end

        // Latency: raw held high from cycle 0 -> request at cycle DEB+3
        $display("[TB] latency sequence");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkValue($sformatf("lat_wait_c%0d", k), {3'b0, vehicleWaiting}, (k >= 7) ? 4'd1 : 4'd0);
            checkValue($sformatf("lat_count_c%0d", k), vehicleCount, (k >= 7) ? 4'd1 : 4'd0);
        end

        // serviceAck in the same cycle as an arrival keeps the new arrival
        $display("[TB] ack-with-arrival sequence");
        applyStimulus(1'b1, 1'b0, 1'b0);
        highLowPair();
        highLowPair();
        checkValue("coinc_pre_count", vehicleCount, 4'd2);
        for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkValue("coinc_pre_count2", vehicleCount, 4'd2);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkValue("coinc_wait", {3'b0, vehicleWaiting}, 4'd1);
        checkValue("coinc_count", vehicleCount, 4'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkValue("coinc_hold_count", vehicleCount, 4'd1);
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("release_keeps_wait", {3'b0, vehicleWaiting}, 4'd1);

        // Reset during qualification discards progress
        $display("[TB] reset-mid-qualification sequence");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkValue($sformatf("rstq_wait_c%0d", k), {3'b0, vehicleWaiting}, (k >= 7) ? 4'd1 : 4'd0);
            checkValue($sformatf("rstq_count_c%0d", k), vehicleCount, (k >= 7) ? 4'd1 : 4'd0);
        end

        // Sensor held high long enough to count as stuck
        $display("[TB] stuck sequence, detection enabled = %0d", STUCK_EN);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 60; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkValue("stuck_fault", {3'b0, sensorStuckFault}, {3'b0, STUCK_EN});
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkValue("stuck_ack_wait", {3'b0, vehicleWaiting}, {3'b0, STUCK_EN});
        checkValue("stuck_ack_count", vehicleCount, 4'd0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkValue("stuck_sticky", {3'b0, sensorStuckFault}, {3'b0, STUCK_EN});
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkValue("stuck_rst_wait", {3'b0, vehicleWaiting}, 4'd0);
        checkValue("stuck_rst_count", vehicleCount, 4'd0);
        checkValue("stuck_rst_fault", {3'b0, sensorStuckFault}, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
